// File: rtl/pulse_test_sequencer_if.sv
// ADC sample, over-temperature flag and sequencer outputs between the ADC side and the pulse generators.
interface pulse_test_sequencer_if;
    logic [15:0] volt;
    logic        volt_vld;
    logic        tem;
    logic        en_a;
    logic        en_b;
    logic [4:0]  led_n;
    logic [1:0]  fault_code;
    logic        busy;

    modport master (output volt, volt_vld, tem, input en_a, en_b, led_n, fault_code, busy);
    modport slave  (input volt, volt_vld, tem, output en_a, en_b, led_n, fault_code, busy);
endinterface

// File: rtl/pulse_test_sequencer.sv
// Qualifies bus voltage and over-temperature, then alternates bursts between channels A and B with dead time.
// Define SEQ_AUTO_RETRY_EN to let FAULT recover after tem clears plus a settle period.
module pulse_test_sequencer #(
    parameter int unsigned SETTLE_CYC = 65535,
    parameter int unsigned QUAL_CNT   = 8,
    parameter logic [15:0] VLO        = 16'h08B0,
    parameter logic [15:0] VHI        = 16'h0C0C,
    parameter int unsigned BURST_CYC  = 400000,
    parameter int unsigned GUARD_CYC  = 8000
) (
    input logic                   clk,
    input logic                   rst_n,
    pulse_test_sequencer_if.slave bus
);
    typedef enum logic [2:0] {SETTLE, QUALIFY, BURST_A, GUARD_A, BURST_B, GUARD_B, FAULT} state_t;

    localparam int unsigned     QW          = $clog2(QUAL_CNT + 1);
    localparam logic [19:0]     SETTLE_LAST = 20'(SETTLE_CYC - 1);
    localparam logic [19:0]     BURST_LAST  = 20'(BURST_CYC - 1);
    localparam logic [19:0]     GUARD_LAST  = 20'(GUARD_CYC - 1);
    localparam logic [QW-1:0]   QUAL_LAST   = QW'(QUAL_CNT - 1);

    state_t      state, next_state;
    logic [19:0] cnt;
    logic [QW-1:0] qcnt;
    logic [1:0]  tem_sync;
    logic        tem_s;
    logic        s_zero, s_under, s_win, s_over, in_run;
    logic [1:0]  next_code, fault_code_q;
    logic        en_a_q, en_b_q, busy_q, en_a_d, en_b_d, busy_d;
    logic [4:0]  led_q, led_d;

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) tem_sync <= '0;
        else        tem_sync <= {tem_sync[0], bus.tem};
    assign tem_s = tem_sync[1];

    assign s_zero  = (bus.volt == 16'h0000);
    assign s_over  = (bus.volt > VHI);
    assign s_win   = (bus.volt > VLO) && !s_over;
    assign s_under = !s_zero && !s_win && !s_over;
    assign in_run  = state inside {BURST_A, GUARD_A, BURST_B, GUARD_B};

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) state <= SETTLE;
        else        state <= next_state;

    always_comb begin
        next_state = state;
        next_code  = fault_code_q;
        case (state)
            SETTLE:  if (cnt >= SETTLE_LAST) next_state = QUALIFY;
            QUALIFY: if (bus.volt_vld && s_win && qcnt >= QUAL_LAST) next_state = BURST_A;
            BURST_A: if (cnt >= BURST_LAST) next_state = GUARD_A;
            GUARD_A: if (cnt >= GUARD_LAST) next_state = BURST_B;
            BURST_B: if (cnt >= BURST_LAST) next_state = GUARD_B;
            GUARD_B: if (cnt >= GUARD_LAST) next_state = BURST_A;
            FAULT: begin
`ifdef SEQ_AUTO_RETRY_EN
                if (!tem_s && cnt >= SETTLE_LAST) begin
                    next_state = QUALIFY;
                    next_code  = 2'd0;
                end
`else
                next_state = FAULT;
`endif
            end
            default: next_state = SETTLE;
        endcase
        // Zero reads as under-voltage; over-temperature overrides any voltage fault.
        if (in_run && bus.volt_vld && !s_win) begin
            next_state = FAULT;
            next_code  = s_over ? 2'd1 : 2'd2;
        end
        if (tem_s && state != SETTLE && state != FAULT) begin
            next_state = FAULT;
            next_code  = 2'd3;
        end
    end

    always_comb begin
        en_a_d = (next_state == BURST_A);
        en_b_d = (next_state == BURST_B);
        busy_d = next_state inside {BURST_A, GUARD_A, BURST_B, GUARD_B};
        led_d  = {next_state != FAULT, led_q[3:0]};
        if (bus.volt_vld) led_d[3:0] = ~{s_zero, s_under, s_win, s_over};
    end

    // The FAULT settle timer restarts for as long as tem_s stays high.
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            cnt  <= '0;
            qcnt <= '0;
        end else begin
            if (next_state != state || (state == FAULT && tem_s)) cnt <= '0;
            else if (cnt != '1)                                   cnt <= cnt + 20'd1;
            if (state != QUALIFY || next_state != QUALIFY) qcnt <= '0;
            else if (bus.volt_vld)
                qcnt <= !s_win ? '0 : (qcnt == '1 ? qcnt : qcnt + QW'(1));
        end

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            en_a_q       <= 1'b0;
            en_b_q       <= 1'b0;
            busy_q       <= 1'b0;
            led_q        <= 5'b11111;
            fault_code_q <= 2'd0;
        end else begin
            en_a_q       <= en_a_d;
            en_b_q       <= en_b_d;
            busy_q       <= busy_d;
            led_q        <= led_d;
            fault_code_q <= next_code;
        end

    assign bus.en_a       = en_a_q;
    assign bus.en_b       = en_b_q;
    assign bus.busy       = busy_q;
    assign bus.led_n      = led_q;
    assign bus.fault_code = fault_code_q;
endmodule

// File: tb/tb_pulse_test_sequencer.sv
// Scoreboard bench: expected output changes are queued with their cycle; the monitor pops on every change.
`timescale 1ns/1ps
module tb_pulse_test_sequencer;
    localparam int S = 200, Q = 8, B = 400, G = 80;

    typedef struct {
        int         c;
        logic       a;
        logic       b;
        logic       bz;
        logic [1:0] fc;
        logic [4:0] led;
    } ev_t;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_bad = 0;
    ev_t  sbq[$];

    pulse_test_sequencer_if bus();

    pulse_test_sequencer #(
        .SETTLE_CYC(S), .QUAL_CNT(Q), .VLO(16'h08B0), .VHI(16'h0C0C),
        .BURST_CYC(B), .GUARD_CYC(G)
    ) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    always #5 clk = ~clk;

    always @(posedge clk)
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;

    // Monitor: scoreboard pop on any output change, plus enable overlap / guard gap check on every rise.
    logic [9:0] prev;
    logic       pa, pb;
    int         last_fall;
    always @(negedge clk) begin
        logic [9:0] cur;
        ev_t        e;
        cur = {bus.en_a, bus.en_b, bus.busy, bus.fault_code, bus.led_n};
        if (!rst_n) begin
            prev = cur;
            pa = 1'b0;
            pb = 1'b0;
            last_fall = -1;
        end else begin
            if (cur !== prev) begin
                n_cmp++;
                if (sbq.size() == 0) begin
                    n_bad++;
                    $display("FAIL unexpected_change cyc=%0d got=%b (no event expected)", cyc, cur);
                end else begin
                    e = sbq.pop_front();
                    if (e.c != cyc || cur !== {e.a, e.b, e.bz, e.fc, e.led}) begin
                        n_bad++;
                        $display("FAIL event got cyc=%0d out=%b, wanted cyc=%0d out=%b",
                                 cyc, cur, e.c, {e.a, e.b, e.bz, e.fc, e.led});
                    end
                end
                prev = cur;
            end
            if ((bus.en_a && !pa) || (bus.en_b && !pb)) begin
                n_cmp++;
                if ((bus.en_a && bus.en_b) || (last_fall >= 0 && cyc - last_fall < G)) begin
                    n_bad++;
                    $display("FAIL enable_rise cyc=%0d en_a=%b en_b=%b gap=%0d, wanted exclusive and gap>=%0d",
                             cyc, bus.en_a, bus.en_b, cyc - last_fall, G);
                end
            end
            if ((!bus.en_a && pa) || (!bus.en_b && pb)) last_fall = cyc;
            pa = bus.en_a;
            pb = bus.en_b;
        end
    end

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s got=%0h want=%0h", nm, got, want);
        end
    endtask

    task automatic ev(input int c, input logic a, input logic b, input logic bz,
                      input logic [1:0] fc, input logic [4:0] led);
        sbq.push_back('{c, a, b, bz, fc, led});
    endtask

    task automatic wait_cyc(input int e);
        while (cyc < e) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic strobe(input int e, input logic [15:0] v);
        wait_cyc(e - 1);
        bus.volt     = v;
        bus.volt_vld = 1'b1;
        @(posedge clk);
        #1;
        bus.volt_vld = 1'b0;
    endtask

    task automatic do_reset();
        #3 rst_n = 1'b0;
        #1;
        chk("rst_en_a", bus.en_a, 0);
        chk("rst_en_b", bus.en_b, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_led_n", bus.led_n, 5'b11111);
        chk("rst_fault_code", bus.fault_code, 0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired at cyc=%0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        bus.volt = 16'h0000;
        bus.volt_vld = 1'b0;
        bus.tem = 1'b0;

        // Phase 1: steady window samples, 4 A/B rounds, over-voltage during the 4th BURST_B.
        do_reset();
        ev(10, 0, 0, 0, 0, 5'b11101);
        for (int i = 0; i < 8; i++) begin
            ev(350 + 480 * i, (i % 2) == 0, (i % 2) == 1, 1, 0, 5'b11101);
            if (i < 7) ev(750 + 480 * i, 0, 0, 1, 0, 5'b11101);
        end
        ev(3770, 0, 0, 0, 1, 5'b01110);
`ifdef SEQ_AUTO_RETRY_EN
        ev(3970, 0, 0, 0, 0, 5'b11110);
`endif
        for (int k = 0; k <= 188; k++) strobe(10 + 20 * k, (k == 188) ? 16'h0D00 : 16'h0A00);
        wait_cyc(4100);
`ifdef SEQ_AUTO_RETRY_EN
        chk("p1_fault_code_after_retry", bus.fault_code, 0);
`else
        chk("p1_fault_code_latched", bus.fault_code, 1);
`endif
        chk("p1_en_b_off", bus.en_b, 0);
        chk("p1_events_drained", sbq.size(), 0);

        // Phase 2: zero sample breaks qualification; tem pulse in GUARD_A beats an under sample.
        do_reset();
        ev(10, 0, 0, 0, 0, 5'b11101);
        ev(350, 0, 0, 0, 0, 5'b10111);
        ev(370, 0, 0, 0, 0, 5'b11101);
        ev(510, 1, 0, 1, 0, 5'b11101);
        ev(910, 0, 0, 1, 0, 5'b11101);
        ev(922, 0, 0, 0, 3, 5'b01011);
`ifdef SEQ_AUTO_RETRY_EN
        ev(1123, 0, 0, 0, 0, 5'b11011);
`endif
        for (int k = 0; k <= 45; k++) strobe(10 + 20 * k, (k == 17) ? 16'h0000 : 16'h0A00);
        wait_cyc(919);
        bus.tem = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        bus.tem = 1'b0;
        bus.volt = 16'h0800;
        bus.volt_vld = 1'b1;
        @(posedge clk); #1;
        bus.volt_vld = 1'b0;
        wait_cyc(924);
        chk("p2_fault_code_tem", bus.fault_code, 3);
        wait_cyc(1300);
`ifdef SEQ_AUTO_RETRY_EN
        chk("p2_fault_code_after_retry", bus.fault_code, 0);
`else
        chk("p2_fault_code_latched", bus.fault_code, 3);
`endif
        chk("p2_events_drained", sbq.size(), 0);

        // Phase 3: asynchronous reset in the middle of BURST_A.
        do_reset();
        ev(10, 0, 0, 0, 0, 5'b11101);
        ev(350, 1, 0, 1, 0, 5'b11101);
        for (int k = 0; k <= 17; k++) strobe(10 + 20 * k, 16'h0A00);
        wait_cyc(400);
        chk("p3_en_a_mid_burst", bus.en_a, 1);
        chk("p3_events_drained", sbq.size(), 0);
        do_reset();
        wait_cyc(20);
        chk("final_events_drained", sbq.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/pulse_test_sequencer.md
# pulse_test_sequencer

Supervisory controller that sequences the two output pulse channels on the PCB test unit. It qualifies the ADC-reported bus voltage and the TEM over-temperature input, then grants bursts alternately to channel A (K_1/K_2 pulse generator) and channel B (K_3/K_4 double-pulse generator), with a dead time between them. It also drives the active-low status LEDs. It sits between the ADC interface and the two pulse generators, replacing their shared static enable.

## Interface
Parameters:
- SETTLE_CYC, 65535: power-up settle cycles before any voltage decision.
- QUAL_CNT, 8: consecutive in-window samples required to start bursting.
- VLO, 16'h08B0: window lower bound, exclusive.
- VHI, 16'h0C0C: window upper bound, inclusive.
- BURST_CYC, 400000: cycles each channel enable stays high per grant.
- GUARD_CYC, 8000: dead-time cycles between grants.

Ports:
- clk  in  1  system clock; the sole clock.
- rst_n  in  1  reset, asynchronous assert, active-low.
- volt  in  16  latest ADC code; valid only when volt_vld is high.
- volt_vld  in  1  one-cycle strobe per conversion (nominally every 8000 cycles).
- tem  in  1  asynchronous over-temperature flag; high means fault.
- en_a  out  1  enable for the channel A pulse generator.
- en_b  out  1  enable for the channel B pulse generator.
- led_n  out  5  status LEDs, active-low: [0] over, [1] in window, [2] under, [3] zero, [4] fault.
- fault_code  out  2  0 none, 1 over-voltage, 2 under-voltage, 3 over-temperature.
- busy  out  1  high in any BURST or GUARD state.

## Operation
- Sample classification on each volt_vld:
  - zero: volt == 0.
  - under: 0 < volt <= VLO.
  - window: VLO < volt <= VHI.
  - over: volt > VHI.
- led_n:
  - Updated only on volt_vld, with the classified bit low and the others high.
  - led_n[4] is low while in FAULT.
- tem passes through a 2-flop synchronizer before use. tem_s is the synchronized value.
- FSM states:
  - SETTLE: count SETTLE_CYC cycles, ignoring samples, then go to QUALIFY.
  - QUALIFY: qcnt increments on each window sample and clears on any other sample. When qcnt reaches QUAL_CNT, go to BURST_A.
  - BURST_A: en_a high for BURST_CYC cycles, then GUARD_A.
  - GUARD_A: both enables low for GUARD_CYC cycles, then BURST_B.
  - BURST_B: same as BURST_A but drives en_b, then GUARD_B.
  - GUARD_B: same as GUARD_A, then BURST_A (continuous alternation).
  - FAULT: both enables low; fault_code held.
- Abort rules:
  - In any BURST or GUARD state, an over or under sample causes FAULT with code 1 or 2. A zero sample counts as under.
  - tem_s high causes FAULT with code 3 from any state except SETTLE, and takes priority over a voltage fault in the same cycle.
  - In QUALIFY, a bad sample only clears qcnt; it does not cause FAULT.
- en_a and en_b are never high together. At least GUARD_CYC low cycles separate their assertions.
- Counters saturate and do not wrap. The cycle counter is 20 bits and is reloaded on every state change.

## Timing
- Reset values:
  - en_a = 0, en_b = 0, busy = 0.
  - led_n = 5'b11111, fault_code = 0.
  - state = SETTLE; all counters 0.
- All outputs are registered.
  - en_a rises one cycle after the QUALIFY→BURST_A transition is decided.
  - en_a stays high for exactly BURST_CYC cycles.
- A fault sample on volt_vld at cycle n drives the enables low at cycle n+1.
- tem to enables-low latency is 3 cycles (2 synchronizer stages plus the output register).
- led_n updates one cycle after volt_vld.
- An asynchronous reset mid-burst drops the enables immediately and restarts at SETTLE.

## Configuration
- SEQ_AUTO_RETRY_EN defined:
  - FAULT waits until tem_s is low, then holds for SETTLE_CYC cycles.
  - It then clears fault_code and re-enters QUALIFY; a fresh qualification is required.
- Undefined: FAULT is latched until rst_n is asserted.

## Test plan
- Reset release, then volt=16'h0A00 strobed every 8000 cycles:
  - No enable during the first 65535 cycles.
  - en_a rises after the 8th in-window sample and is high for 400000 cycles.
  - en_b rises exactly 8000 cycles after en_a falls.
- Alternation for 3 full cycles: checker confirms en_a&en_b never high and every guard gap is ≥8000 cycles.
- volt=16'h0D00 during BURST_B: en_b low on the next cycle, fault_code=1, led_n=5'b01110.
- tem pulsed high for 2 cycles during GUARD_A: fault_code=3 three cycles later. It wins over a simultaneous volt=16'h0800 sample.
- In QUALIFY, 7 window samples, then 16'h0000, then 8 window samples: burst starts only after the second run, and led_n[3] is low after the zero sample.
- Fault, then tem low:
  - With SEQ_AUTO_RETRY_EN, re-qualification occurs after 65535 cycles.
  - Without it, the block stays in FAULT until rst_n pulses.
